// File: rtl/blob_record_fifo.sv
// Validates/size-filters finished component boxes, emits {cx,cy,ex,ey} records through a show-ahead FIFO.
// Latency 2 cycles in to out_valid; input never stalls, records arriving while full (no pop) are dropped and counted.
module blob_record_fifo #(
  parameter int x_bit    = 9,
  parameter int y_bit    = 9,
  parameter int data_bit = 36,
  parameter int min_w    = 2,
  parameter int min_h    = 2,
  parameter int max_w    = 64,
  parameter int max_h    = 64,
  parameter int fifo_aw  = 4,
  parameter int cnt_bit  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [data_bit-1:0]          in_data,
  input  logic                         frame_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*x_bit+2*y_bit-1:0]   out_data,
  output logic [fifo_aw:0]             fifo_level,
  output logic [cnt_bit-1:0]           frame_blobs,
  output logic [cnt_bit-1:0]           drop_cnt
);

  localparam int OW    = 2*x_bit + 2*y_bit;
  localparam int DEPTH = 1 << fifo_aw;
  localparam logic [x_bit:0] MIN_W = (x_bit+1)'(min_w);
  localparam logic [x_bit:0] MAX_W = (x_bit+1)'(max_w);
  localparam logic [y_bit:0] MIN_H = (y_bit+1)'(min_h);
  localparam logic [y_bit:0] MAX_H = (y_bit+1)'(max_h);

  logic [x_bit-1:0] minx, maxx, cx_d, ex_d;
  logic [y_bit-1:0] miny, maxy, cy_d, ey_d;
  logic             pass_d;

  assign minx = in_data[OW-1 -: x_bit];
  assign maxx = in_data[OW-1-x_bit -: x_bit];
  assign miny = in_data[2*y_bit-1 -: y_bit];
  assign maxy = in_data[y_bit-1:0];

  // Sizes are compared one bit wider so a full-width box does not wrap to zero.
  always_comb begin
    ex_d   = maxx - minx;
    ey_d   = maxy - miny;
    cx_d   = x_bit'(({1'b0, minx} + {1'b0, maxx}) >> 1);
    cy_d   = y_bit'(({1'b0, miny} + {1'b0, maxy}) >> 1);
    pass_d = (minx <= maxx) && (miny <= maxy) &&
             (({1'b0, ex_d} + 1'b1) >= MIN_W) && (({1'b0, ex_d} + 1'b1) <= MAX_W) &&
             (({1'b0, ey_d} + 1'b1) >= MIN_H) && (({1'b0, ey_d} + 1'b1) <= MAX_H);
  end

  logic              s1_vld_q;
  logic [OW-1:0]     s1_rec_q;
  logic [OW-1:0]     mem_q [DEPTH];
  logic [fifo_aw:0]  wr_ptr_q, rd_ptr_q;
  logic [cnt_bit-1:0] blob_cnt_q, frame_blobs_q, drop_cnt_q;
  logic [cnt_bit-1:0] blob_sum_d, blob_cnt_d, frame_blobs_d, drop_cnt_d;
  logic              empty, full, pop, push, drop;

  // Wrap bit differs with equal index bits means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[fifo_aw] != rd_ptr_q[fifo_aw]) &&
                 (wr_ptr_q[fifo_aw-1:0] == rd_ptr_q[fifo_aw-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = s1_vld_q && (!full || pop);
  assign drop  = s1_vld_q && full && !pop;

  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : mem_q[rd_ptr_q[fifo_aw-1:0]];
  assign fifo_level  = wr_ptr_q - rd_ptr_q;
  assign frame_blobs = frame_blobs_q;
  assign drop_cnt    = drop_cnt_q;

  // A write landing on the frame_done cycle is credited to the closing frame.
  always_comb begin
    blob_sum_d = blob_cnt_q;
    if (push && blob_cnt_q != '1) blob_sum_d = blob_cnt_q + 1'b1;
    blob_cnt_d    = frame_done ? '0 : blob_sum_d;
    frame_blobs_d = frame_done ? blob_sum_d : frame_blobs_q;
    drop_cnt_d    = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      blob_cnt_q    <= '0;
      frame_blobs_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      s1_vld_q      <= in_valid && pass_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      blob_cnt_q    <= blob_cnt_d;
      frame_blobs_q <= frame_blobs_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_rec_q <= {cx_d, cy_d, ex_d, ey_d};
    if (push && !rst) mem_q[wr_ptr_q[fifo_aw-1:0]] <= s1_rec_q;
  end

endmodule

// File: tb/tb_blob_record_fifo.sv
// Scoreboard bench for blob_record_fifo: records queued at the modelled FIFO write, compared on each pop.
module tb_blob_record_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [35:0] in_data = '0;
  logic        frame_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [35:0] out_data;
  logic [4:0]  fifo_level;
  logic [7:0]  frame_blobs;
  logic [7:0]  drop_cnt;

  blob_record_fifo dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .frame_done(frame_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_level(fifo_level), .frame_blobs(frame_blobs),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] exp_q [$];
  logic        pend_vld = 1'b0;
  logic [35:0] pend_rec = '0;
  int          drop_exp = 0;
  int          blob_exp = 0;
  int          fb_exp   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [35:0] d, output logic p, output logic [35:0] r);
    int mnx, mxx, mny, mxy, w, h, cx, cy, ex, ey;
    mnx = int'(d[35:27]); mxx = int'(d[26:18]);
    mny = int'(d[17:9]);  mxy = int'(d[8:0]);
    w = mxx - mnx + 1; h = mxy - mny + 1;
    p = (mnx <= mxx) && (mny <= mxy) && (w >= 2) && (w <= 64) && (h >= 2) && (h <= 64);
    cx = (mnx + mxx) / 2; cy = (mny + mxy) / 2;
    ex = mxx - mnx;       ey = mxy - mny;
    r = {cx[8:0], cy[8:0], ex[8:0], ey[8:0]};
  endfunction

  // One clock: advance the reference model for this edge, then check the state.
  task automatic step();
    logic wr, p;
    logic [35:0] r;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pend_vld = 1'b0;
      drop_exp = 0; blob_exp = 0; fb_exp = 0;
    end else begin
      wr = 1'b0;
      if (pend_vld) begin
        if (exp_q.size() < 16) begin
          exp_q.push_back(pend_rec);
          wr = 1'b1;
        end else if (drop_exp < 255) begin
          drop_exp++;
        end
      end
      if (frame_done) begin
        fb_exp   = (blob_exp + int'(wr) > 255) ? 255 : blob_exp + int'(wr);
        blob_exp = 0;
      end else if (wr && blob_exp < 255) begin
        blob_exp++;
      end
      model(in_data, p, r);
      pend_vld = in_valid && p;
      pend_rec = r;
    end
    #1;
    check("level", 64'(fifo_level), 64'(exp_q.size()));
    check("drop", 64'(drop_cnt), 64'(drop_exp));
    check("fblobs", 64'(frame_blobs), 64'(fb_exp));
    check("ovalid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() == 0) check("odata_empty", 64'(out_data), 64'd0);
  endtask

  task automatic push(input int a, input int b, input int c, input int e);
    in_valid = 1'b1;
    in_data  = {a[8:0], b[8:0], c[8:0], e[8:0]};
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_empty", 64'(fifo_level), 64'd0);
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else                   check("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_odata", 64'(out_data), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    // Basic record, 2-cycle latency
    push(10, 20, 4, 9);
    check("lat_early", 64'(out_valid), 64'd0);
    step();
    check("basic_vld", 64'(out_valid), 64'd1);
    check("basic_dat", 64'(out_data), 64'({9'd15, 9'd6, 9'd10, 9'd5}));
    check("basic_lvl", 64'(fifo_level), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("basic_pop_lvl", 64'(fifo_level), 64'd0);
    check("basic_pop_vld", 64'(out_valid), 64'd0);

    // Filtering
    push(5, 5, 0, 9);
    push(0, 64, 0, 9);
    push(511, 0, 511, 0);
    push(0, 63, 0, 1);
    step();
    check("filt_lvl", 64'(fifo_level), 64'd1);
    check("filt_dat", 64'(out_data), 64'({9'd31, 9'd0, 9'd63, 9'd1}));
    check("filt_drop", 64'(drop_cnt), 64'd0);
    drain();

    // Overflow
    for (int i = 0; i < 18; i++) push(i, i + 5, i, i + 3);
    step();
    check("ovf_lvl", 64'(fifo_level), 64'd16);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_head", 64'(out_data), 64'({9'd2, 9'd1, 9'd5, 9'd3}));
    push(100, 110, 50, 60);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ovf_pw_lvl", 64'(fifo_level), 64'd16);
    check("ovf_pw_drop", 64'(drop_cnt), 64'd2);
    drain();

    // Frame counting
    out_ready = 1'b1;
    frame_done = 1'b1; step(); frame_done = 1'b0;
    for (int i = 0; i < 4; i++) push(20 + i, 30 + i, 1, 5);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("fb_4", 64'(frame_blobs), 64'd4);
    push(7, 9, 7, 9);
    step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("fb_1", 64'(frame_blobs), 64'd1);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("fb_0", 64'(frame_blobs), 64'd0);
    drain();

    // Saturation then streaming
    for (int i = 0; i < 300; i++) push(i % 400, i % 400 + 3, i % 200, i % 200 + 2);
    step();
    check("sat_drop", 64'(drop_cnt), 64'd255);
    check("sat_lvl", 64'(fifo_level), 64'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) push(2 * i, 2 * i + 10, i, i + 20);
    drain();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    check("fb_sat", 64'(frame_blobs), 64'd66);

    // Reset mid-stream
    for (int i = 0; i < 6; i++) push(40 + i, 50 + i, 3, 8);
    check("rst_pre_lvl", 64'(fifo_level), 64'd5);
    rst = 1'b1; step(); rst = 1'b0;
    check("mrst_ovalid", 64'(out_valid), 64'd0);
    check("mrst_level", 64'(fifo_level), 64'd0);
    check("mrst_drop", 64'(drop_cnt), 64'd0);
    check("mrst_fb", 64'(frame_blobs), 64'd0);
    repeat (3) step();
    check("mrst_no_ghost", 64'(fifo_level), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) push(i, i + 1, 2 * i, 2 * i + 7);
    drain();
    check("stream_drop", 64'(drop_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blob_record_fifo.md
# blob_record_fifo

Downstream stage of the feature accumulator in the CCA pipeline. It takes each resolved component's packed bounding box {minx,maxx,miny,maxy} as the component is finalised and produces a readout record. Each box is first validated and size-filtered. The block then computes the centroid and extents and buffers the record in a FIFO for a valid/ready consumer. It also keeps per-frame blob counts and a saturating overflow counter.

## Interface
- x_bit, 9, x coordinate width
- y_bit, 9, y coordinate width
- data_bit, 36, input record width; equals 2*x_bit+2*y_bit
- min_w, 2, minimum accepted box width in pixels (maxx-minx+1)
- min_h, 2, minimum accepted box height in pixels
- max_w, 64, maximum accepted box width
- max_h, 64, maximum accepted box height
- fifo_aw, 4, FIFO address bits; depth 2^fifo_aw
- cnt_bit, 8, width of frame_blobs and drop_cnt
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds one finished component this cycle
- in_data  in  data_bit  packing {minx[x_bit], maxx[x_bit], miny[y_bit], maxy[y_bit]}, MSB first
- frame_done  in  1  one-cycle pulse at end of frame
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid&out_ready
- out_data  out  2*x_bit+2*y_bit  {cx, cy, ex, ey}; ex=maxx-minx, ey=maxy-miny (size minus one)
- fifo_level  out  fifo_aw+1  current occupancy, 0..2^fifo_aw
- frame_blobs  out  cnt_bit  accepted-blob count of last completed frame
- drop_cnt  out  cnt_bit  records lost to FIFO full since reset; saturating

## Operation
- **Stage 1**, registered on an in_valid cycle: unpack the fields and compute the following.
  - ex=maxx-minx and ey=maxy-miny, both modular and x_bit/y_bit wide.
  - cx=(minx+maxx)>>1 and cy=(miny+maxy)>>1, from (x_bit+1)/(y_bit+1)-bit sums, floor.
  - pass flag.
- pass=1 requires all of the following:
  - minx<=maxx and miny<=maxy. A cleared/empty record (minx all-ones, maxx 0) fails, is discarded silently, and is not counted anywhere.
  - ex+1 in [min_w,max_w] and ey+1 in [min_h,max_h]. Compare with one extra bit so that size 2^x_bit does not wrap.
- Stage 1 is a single register slot with no backpressure to the input. A new in_valid every cycle must be sustained.
- **Stage 2 (write)**: if stage-1 valid and pass, write {cx,cy,ex,ey} into the FIFO.
  - Full and no pop in the same cycle: drop the record and increment drop_cnt, holding at all-ones.
  - Full with a simultaneous pop: the write is accepted and the level is unchanged.
- **FIFO**: circular buffer with read/write pointers of fifo_aw+1 bits (wrap bit distinguishes full from empty).
  - out_data is show-ahead: it always reflects the head entry.
  - Pop on out_valid&out_ready. A pop while empty is ignored.
- **Frame counter**: blob_cnt increments on each accepted FIFO write, saturating at all-ones.
  - On frame_done, frame_blobs<=blob_cnt plus the current-cycle write if one occurs, and blob_cnt<=0. A write coinciding with frame_done belongs to the closing frame.
  - Dropped records are not counted in blob_cnt.

## Timing
- Reset, synchronous, values after the rst edge:
  - FIFO empty, stage 1 invalid.
  - out_valid=0, fifo_level=0, frame_blobs=0, drop_cnt=0.
  - out_data=0: storage need not reset, but the output is masked to 0 while empty.
- An in_valid sampled at edge N enters stage 1 at N. The FIFO write happens at edge N+1. out_valid=1 at the earliest after edge N+1, giving a 2-cycle latency.
- fifo_level updates on the same edge as the write/pop: +1 write only, -1 pop only, 0 for both or neither.
- rst asserted mid-operation overrides all writes, pops and frame_done in that cycle. Records held in stage 1 are lost.
- Throughput is 1 record/cycle in and 1 out.

## Test plan
- **Basic record**: reset, then in_data minx=10, maxx=20, miny=4, maxy=9. Required: out_valid 2 cycles later, out_data cx=15, cy=6, ex=10, ey=5, fifo_level=1. Pop it and check fifo_level=0, out_valid=0.
- **Filtering**:
  - minx=5, maxx=5 (width 1 < min_w=2): discarded.
  - Width 65: discarded.
  - Cleared record {1FF,000,1FF,000}: discarded.
  - Width 64, height 2: accepted.
  - drop_cnt stays 0 throughout.
- **Overflow**:
  - Hold out_ready=0 and push 18 valid boxes back-to-back. Required: fifo_level=16, drop_cnt=2, and the FIFO holds the first 16 in order.
  - Then push one more with out_ready=1 while full: accepted, level stays 16, drop_cnt stays 2.
- **Frame count**:
  - 3 accepted blobs, then frame_done coincident with a 4th write. Required: frame_blobs=4, and a following blob makes blob_cnt count from 1.
  - frame_done with no blobs gives frame_blobs=0.
- **Saturation and streaming**: push 300 records with out_ready=0 (cnt_bit=8). Required: drop_cnt saturates at 255. Then stream in_valid every cycle with out_ready=1: no drops, and output order matches input order.
- **Reset mid-stream**: assert rst with 5 queued records and one in stage 1. Required: the next cycle shows out_valid=0, fifo_level=0 and zeroed counters, and the stage-1 record never appears.
